alarm_input_conditioner: RTL

Front-end conditioning stage for the security FSM. Takes three raw asynchronous panel signals: arm push-button, door/motion sensor and alarm-enable switch. It synchronises and debounces each one, then applies an exit delay to the arm request. It drives the clean arm / sensor / on signals consumed directly by the downstream alarm state machine.

---
 rtl/alarm_input_conditioner_if.sv | 26 ++
 rtl/alarm_input_conditioner.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alarm_input_conditioner_if.sv
// Panel-side signal bundle for the alarm input conditioner.
// Raw bouncy inputs flow in; clean arm/sensor/on levels flow out to the alarm FSM.
interface alarm_input_conditioner_if #(
  parameter int CNT_W = 8
) ();
  logic             raw_arm_btn;
  logic             raw_sensor;
  logic             raw_on_sw;
  logic             arm;
  logic             sensor;
  logic             on;
  logic             exit_pending;
  logic [CNT_W-1:0] exit_count;

  // Panel side: drives raw inputs, observes conditioned outputs.
  modport master (
    output raw_arm_btn, raw_sensor, raw_on_sw,
    input  arm, sensor, on, exit_pending, exit_count
  );

  // Conditioner side.
  modport slave (
    input  raw_arm_btn, raw_sensor, raw_on_sw,
    output arm, sensor, on, exit_pending, exit_count
  );
endinterface

// File: rtl/alarm_input_conditioner.sv
// Synchronises and debounces the three panel inputs, then runs the arm exit delay
// that produces a single-cycle arm request and masks the sensor while it runs.
module alarm_input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int EXIT_DELAY = 16,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alarm_input_conditioner_if.slave bus
);

  localparam int CH_ARM = 0;
  localparam int CH_SEN = 1;
  localparam int CH_ON  = 2;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXIT_LAST = CNT_W'(EXIT_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXIT_WAIT = 2'd1,
    PULSE     = 2'd2,
    HOLD      = 2'd3
  } state_t;

  logic [2:0]       raw;
  logic [2:0]       s1_q, s2_q;
  logic [2:0]       db_q, db_d;
  logic [CNT_W-1:0] dc_q [3];
  logic [CNT_W-1:0] dc_d [3];
  logic             btn_prev_q;
  logic             press;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] exit_cnt_q, exit_cnt_d;

  assign raw = {bus.raw_on_sw, bus.raw_sensor, bus.raw_arm_btn};

  // Counter clears whenever the sample agrees with db, so short glitches never land.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i] = db_q[i];
      dc_d[i] = dc_q[i];
      if (s2_q[i] == db_q[i]) begin
        dc_d[i] = '0;
      end else if (dc_q[i] == DEB_LAST) begin
        db_d[i] = s2_q[i];
        dc_d[i] = '0;
      end else begin
        dc_d[i] = dc_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      db_q       <= '0;
      btn_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) dc_q[i] <= '0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      db_q       <= db_d;
      btn_prev_q <= db_q[CH_ARM];
      for (int i = 0; i < 3; i++) dc_q[i] <= dc_d[i];
    end
  end

  assign press = db_q[CH_ARM] & ~btn_prev_q;

  // A second press during the delay cancels it, even on the expiry cycle.
  always_comb begin
    state_d    = state_q;
    exit_cnt_d = exit_cnt_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d    = EXIT_WAIT;
          exit_cnt_d = EXIT_LAST;
        end
      end
      EXIT_WAIT: begin
        if (press) begin
          state_d    = IDLE;
          exit_cnt_d = '0;
        end else if (exit_cnt_q == '0) begin
          state_d = PULSE;
        end else begin
          exit_cnt_d = exit_cnt_q - 1'b1;
        end
      end
      PULSE: state_d = HOLD;
      HOLD: begin
        if (!db_q[CH_ARM]) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        exit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exit_cnt_q <= exit_cnt_d;
    end
  end

  assign bus.arm          = (state_q == PULSE);
  assign bus.exit_pending = (state_q == EXIT_WAIT);
  assign bus.sensor       = db_q[CH_SEN] & ~(state_q == EXIT_WAIT);
  assign bus.on           = db_q[CH_ON];
  assign bus.exit_count   = exit_cnt_q;

endmodule
